// File: rtl/axi_lite_aw_rr_arbiter.sv
// Round-robin arbiter muxing NUM_REQ AXI-lite write-address channels into one registered output beat.
// Latency: requester handshake in cycle N gives m_awvalid in cycle N+1; one beat per cycle sustained.
// Backpressure: m_awready low while full holds the beat stable and deasserts every req_awready.
module axi_lite_aw_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_awaddr,
    input  logic [NUM_REQ-1:0]        req_awvalid,
    output logic [NUM_REQ-1:0]        req_awready,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [ID_W-1:0]           m_awid,
    output logic [ID_W-1:0]           rr_ptr
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state;
    logic            can_accept;
    logic            win_vld;
    logic [ID_W-1:0] win_idx;
    logic [ID_W-1:0] nxt_ptr;
    logic [ID_W:0]   scan_idx;

    // Scan from the highest offset down so the last hit is the first valid at or after rr_ptr.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (req_awvalid[scan_idx[ID_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan_idx[ID_W-1:0];
            end
        end
    end

    assign nxt_ptr = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);

    // Gated by reset_n so no requester sees a handshake the held-in-reset register would drop.
    assign can_accept = reset_n & ((state == EMPTY) | m_awready);

    always_comb begin
        req_awready = '0;
        if (can_accept && win_vld) begin
            req_awready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= EMPTY;
            m_awaddr <= '0;
            m_awid   <= '0;
            rr_ptr   <= '0;
        end else if (can_accept) begin
            if (win_vld) begin
                state    <= FULL;
                m_awaddr <= req_awaddr[win_idx*ADDR_W +: ADDR_W];
                m_awid   <= win_idx;
                rr_ptr   <= nxt_ptr;
            end else begin
                state <= EMPTY;
            end
        end
    end

    assign m_awvalid = (state == FULL);

endmodule

// File: tb/tb_axi_lite_aw_rr_arbiter.sv
// Bench for axi_lite_aw_rr_arbiter: 4-requester instance checked against a scoreboard model,
// plus a 3-requester instance checked for wrap order.
module tb_axi_lite_aw_rr_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  id;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] req_awaddr = '0;
    logic [3:0]   req_awvalid = '0;
    logic [3:0]   req_awready;
    logic [31:0]  m_awaddr;
    logic         m_awvalid;
    logic         m_awready = 1'b0;
    logic [1:0]   m_awid;
    logic [1:0]   rr_ptr;

    logic [95:0]  req3_awaddr = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    logic [2:0]   req3_awvalid = 3'b111;
    logic [2:0]   req3_awready;
    logic [31:0]  m3_awaddr;
    logic         m3_awvalid;
    logic         m3_awready = 1'b1;
    logic [1:0]   m3_awid;
    logic [1:0]   rr3_ptr;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t sb_q[$];
    bit    mdl_full = 0;
    int    mdl_ptr = 0;
    bit    mdl3_full = 0;
    int    mdl3_ptr = 0;
    int    mdl3_id = 0;

    always #5 clk = ~clk;

    axi_lite_aw_rr_arbiter #(.NUM_REQ(4), .ADDR_W(32)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_awaddr(req_awaddr), .req_awvalid(req_awvalid), .req_awready(req_awready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awid(m_awid), .rr_ptr(rr_ptr)
    );

    axi_lite_aw_rr_arbiter #(.NUM_REQ(3), .ADDR_W(32)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_awaddr(req3_awaddr), .req_awvalid(req3_awvalid), .req_awready(req3_awready),
        .m_awaddr(m3_awaddr), .m_awvalid(m3_awvalid), .m_awready(m3_awready),
        .m_awid(m3_awid), .rr_ptr(rr3_ptr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] v, input int ptr, input int n);
        for (int i = 0; i < n; i++) begin
            if (v[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 4-requester instance: predict grants, push accepted beats, pop on drain.
    always @(negedge clk) begin : mon4
        int    g;
        beat_t e;
        if (!reset_n) begin
            sb_q.delete();
            mdl_full = 0;
            mdl_ptr  = 0;
            chk("rst_rdy", 64'(req_awready), 64'd0);
        end else begin
            chk("vld", 64'(m_awvalid), 64'(mdl_full));
            chk("ptr", 64'(rr_ptr), 64'(mdl_ptr));
            if (mdl_full && m_awready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("addr", 64'(m_awaddr), 64'(e.addr));
                    chk("id", 64'(m_awid), 64'(e.id));
                end
            end
            g = (!mdl_full || m_awready) ? rr_pick(req_awvalid, mdl_ptr, 4) : -1;
            chk("rdy", 64'(req_awready), (g >= 0) ? 64'(4'b0001 << g) : 64'd0);
            if (g >= 0) begin
                e.addr = req_awaddr[g*32 +: 32];
                e.id   = 2'(g);
                sb_q.push_back(e);
                mdl_full = 1;
                mdl_ptr  = (g + 1) % 4;
            end else if (mdl_full && m_awready) begin
                mdl_full = 0;
            end
        end
    end

    // 3-requester instance: all valid, always ready, so grants must walk 0,1,2,0...
    always @(negedge clk) begin : mon3
        if (!reset_n) begin
            mdl3_full = 0;
            mdl3_ptr  = 0;
            chk("rst_rdy3", 64'(req3_awready), 64'd0);
        end else begin
            chk("vld3", 64'(m3_awvalid), 64'(mdl3_full));
            chk("ptr3", 64'(rr3_ptr), 64'(mdl3_ptr));
            if (mdl3_full) begin
                chk("id3", 64'(m3_awid), 64'(mdl3_id));
                chk("addr3", 64'(m3_awaddr), 64'(req3_awaddr[mdl3_id*32 +: 32]));
            end
            chk("rdy3", 64'(req3_awready), 64'(3'b001 << mdl3_ptr));
            mdl3_id   = mdl3_ptr;
            mdl3_full = 1;
            mdl3_ptr  = (mdl3_ptr + 1) % 3;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] hold_addr;
        logic [1:0]  hold_id;

        // Reset with every requester valid: no ready may leak out.
        req_awvalid = 4'b1111;
        m_awready   = 1'b1;
        req_awaddr  = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) cyc();
        chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_m_awaddr", 64'(m_awaddr), 64'd0);
        chk("rst_m_awid", 64'(m_awid), 64'd0);
        chk("rst_rr_ptr", 64'(rr_ptr), 64'd0);

        // Single requester 2.
        reset_n     = 1'b1;
        req_awvalid = 4'b0100;
        req_awaddr[2*32 +: 32] = 32'h1000_0020;
        #1 chk("single_rdy", 64'(req_awready), 64'h4);
        cyc();
        chk("single_vld", 64'(m_awvalid), 64'd1);
        chk("single_addr", 64'(m_awaddr), 64'h1000_0020);
        chk("single_id", 64'(m_awid), 64'd2);
        chk("single_ptr", 64'(rr_ptr), 64'd3);

        // Wrap from 3 to 0, then skip forward to 1.
        req_awvalid = 4'b0011;
        #1 chk("wrap_rdy", 64'(req_awready), 64'h1);
        cyc();
        chk("wrap_id", 64'(m_awid), 64'd0);
        chk("wrap_ptr", 64'(rr_ptr), 64'd1);
        #1 chk("skip_rdy", 64'(req_awready), 64'h2);
        cyc();
        chk("skip_id", 64'(m_awid), 64'd1);
        chk("skip_ptr", 64'(rr_ptr), 64'd2);

        // All valid, always ready: back-to-back beats in rotating order.
        req_awvalid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            req_awaddr = {$urandom, $urandom, $urandom, $urandom};
            cyc();
            chk("rr_seq_id", 64'(m_awid), 64'((2 + k) % 4));
            chk("rr_seq_vld", 64'(m_awvalid), 64'd1);
        end

        // Backpressure: beat held for 5 cycles while others keep requesting.
        m_awready = 1'b0;
        hold_addr = m_awaddr;
        hold_id   = m_awid;
        for (int k = 0; k < 5; k++) begin
            req_awaddr = {$urandom, $urandom, $urandom, $urandom};
            #1 chk("bp_rdy", 64'(req_awready), 64'd0);
            cyc();
            chk("bp_addr", 64'(m_awaddr), 64'(hold_addr));
            chk("bp_id", 64'(m_awid), 64'(hold_id));
        end
        m_awready = 1'b1;
        #1 chk("bp_release_rdy", 64'(req_awready), 64'(4'b0001 << mdl_ptr));
        cyc();

        // Random traffic against the scoreboard.
        for (int k = 0; k < 300; k++) begin
            req_awvalid = 4'($urandom);
            m_awready   = ($urandom % 4) != 0;
            req_awaddr  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        // Async reset while full, between edges.
        req_awvalid = 4'b0001;
        m_awready   = 1'b0;
        cyc();
        req_awvalid = 4'b0000;
        cyc();
        chk("pre_arst_vld", 64'(m_awvalid), 64'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_vld", 64'(m_awvalid), 64'd0);
        chk("arst_ptr", 64'(rr_ptr), 64'd0);
        chk("arst_rdy", 64'(req_awready), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        reset_n     = 1'b1;
        req_awvalid = 4'b1000;
        m_awready   = 1'b1;
        req_awaddr[3*32 +: 32] = 32'hCAFE_0003;
        #1 chk("post_arst_rdy", 64'(req_awready), 64'h8);
        cyc();
        chk("post_arst_id", 64'(m_awid), 64'd3);
        chk("post_arst_addr", 64'(m_awaddr), 64'hCAFE_0003);
        req_awvalid = 4'b0000;
        repeat (3) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
